// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between sysid_checker (master) and the system ID slave.
//   m_address     : word select (0 = ID, 1 = timestamp)
//   m_read        : read request
//   m_waitrequest : slave stall
//   m_readdata    : read data, valid when m_read=1 and m_waitrequest=0
interface sysid_checker_if;
  logic        m_address;
  logic        m_read;
  logic        m_waitrequest;
  logic [31:0] m_readdata;

  modport master (
    output m_address,
    output m_read,
    input  m_waitrequest,
    input  m_readdata
  );

  modport slave (
    input  m_address,
    input  m_read,
    output m_waitrequest,
    output m_readdata
  );
endinterface

// File: rtl/sysid_checker.sv
// Reads the system ID word and timestamp word after reset (optional) or on a start pulse,
// compares them with build-time values and reports sticky pass/error flags.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   start          : single-cycle check request, honoured only when idle
//   bus            : Avalon-MM master port (m_address, m_read, m_waitrequest, m_readdata)
//   busy           : check in progress
//   done           : one-cycle pulse at the end of a check
//   pass           : both words matched (sticky)
//   id_err, ts_err, timeout_err : sticky error flags
//   id_value, ts_value          : last captured words
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID = 32'd28,
  parameter logic [31:0] EXPECTED_TS = 32'd1718188374,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned RETRIES     = 3,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  sysid_checker_if.master        bus,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   id_err,
  output logic                   ts_err,
  output logic                   timeout_err,
  output logic [31:0]            id_value,
  output logic [31:0]            ts_value
);

  typedef enum logic [2:0] {StIdle, StRdId, StRdTs, StGap, StCheck} state_e;

  localparam state_e     StReset  = AUTO_START ? StRdId : StIdle;
  localparam logic [15:0] TmoLim  = 16'(TIMEOUT);
  localparam logic [3:0]  RetryLim = 4'(RETRIES);

  state_e      state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic [3:0]  retry_q, retry_d;
  logic        m_read_q, m_read_d;
  logic        m_address_q, m_address_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        id_err_q, id_err_d;
  logic        ts_err_q, ts_err_d;
  logic        tmo_err_q, tmo_err_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic accept, stall, tmo_hit, retry_left;

  // m_read_q can be low in StRdId right after reset release; nothing is accepted until it rises.
  assign accept     = m_read_q & ~bus.m_waitrequest;
  assign stall      = m_read_q & bus.m_waitrequest;
  assign tmo_hit    = (TmoLim != 16'd0) && stall && (tmo_q == TmoLim - 16'd1);
  assign retry_left = (retry_q < RetryLim);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRdId;
      StRdId:  if (accept) state_d = StRdTs; else if (tmo_hit) state_d = StGap;
      StRdTs:  if (accept) state_d = StCheck; else if (tmo_hit) state_d = StGap;
      // The held address tells which read to re-issue.
      StGap:   state_d = retry_left ? (m_address_q ? StRdTs : StRdId) : StIdle;
      StCheck: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    tmo_d      = tmo_q;
    retry_d    = retry_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    id_err_d   = id_err_q;
    ts_err_d   = ts_err_q;
    tmo_err_d  = tmo_err_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pass_d    = 1'b0;
          id_err_d  = 1'b0;
          ts_err_d  = 1'b0;
          tmo_err_d = 1'b0;
          retry_d   = 4'd0;
          tmo_d     = 16'd0;
        end
      end
      StRdId, StRdTs: begin
        if (accept) begin
          if (m_address_q) ts_value_d = bus.m_readdata;
          else             id_value_d = bus.m_readdata;
          tmo_d = 16'd0;
        end else if (stall) begin
          tmo_d = tmo_hit ? 16'd0 : tmo_q + 16'd1;
        end
      end
      StGap: begin
        if (retry_left) begin
          retry_d = retry_q + 4'd1;
        end else begin
          tmo_err_d = 1'b1;
          pass_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      StCheck: begin
        id_err_d = (id_value_q != EXPECTED_ID);
        ts_err_d = (ts_value_q != EXPECTED_TS);
        pass_d   = (id_value_q == EXPECTED_ID) && (ts_value_q == EXPECTED_TS);
        done_d   = 1'b1;
      end
      default: ;
    endcase

    // Bus outputs are registered from the next state so a read is on the bus the
    // cycle the FSM enters a read state; the address is held through GAP.
    m_read_d    = (state_d == StRdId) || (state_d == StRdTs);
    m_address_d = m_address_q;
    if (state_d == StRdId) m_address_d = 1'b0;
    if (state_d == StRdTs) m_address_d = 1'b1;
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q       <= 16'd0;
      retry_q     <= 4'd0;
      m_read_q    <= 1'b0;
      m_address_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      id_err_q    <= 1'b0;
      ts_err_q    <= 1'b0;
      tmo_err_q   <= 1'b0;
      id_value_q  <= 32'd0;
      ts_value_q  <= 32'd0;
    end else begin
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      m_read_q    <= m_read_d;
      m_address_q <= m_address_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      id_err_q    <= id_err_d;
      ts_err_q    <= ts_err_d;
      tmo_err_q   <= tmo_err_d;
      id_value_q  <= id_value_d;
      ts_value_q  <= ts_value_d;
    end
  end

  assign bus.m_read    = m_read_q;
  assign bus.m_address = m_address_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign id_err        = id_err_q;
  assign ts_err        = ts_err_q;
  assign timeout_err   = tmo_err_q;
  assign id_value      = id_value_q;
  assign ts_value      = ts_value_q;

endmodule

// File: tb/tb_sysid_checker.sv
module tb_sysid_checker;
  localparam logic [31:0] EXP_ID    = 32'd28;
  localparam logic [31:0] EXP_TS    = 32'd1718188374;
  localparam int          T_TIMEOUT = 4;
  localparam int          T_RETRIES = 1;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic start_t = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Main DUT: default parameters, auto-start
  sysid_checker_if bus ();
  logic busy, done, pass, id_err, ts_err, timeout_err;
  logic [31:0] id_value, ts_value;

  sysid_checker dut (
    .clock(clock), .reset_n(reset_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .id_err(id_err), .ts_err(ts_err),
    .timeout_err(timeout_err), .id_value(id_value), .ts_value(ts_value)
  );

  // Timeout DUT: short timeout, one retry, slave stalls forever
  sysid_checker_if tbus ();
  logic t_busy, t_done, t_pass, t_id_err, t_ts_err, t_timeout_err;
  logic [31:0] t_id_value, t_ts_value;

  sysid_checker #(.TIMEOUT(T_TIMEOUT), .RETRIES(T_RETRIES), .AUTO_START(1'b0)) dut_t (
    .clock(clock), .reset_n(reset_n), .start(start_t), .bus(tbus),
    .busy(t_busy), .done(t_done), .pass(t_pass), .id_err(t_id_err), .ts_err(t_ts_err),
    .timeout_err(t_timeout_err), .id_value(t_id_value), .ts_value(t_ts_value)
  );

  assign tbus.m_waitrequest = 1'b1;
  assign tbus.m_readdata    = 32'hdead_beef;

  // Slave model for the main DUT: stalls each address for a configured number of cycles.
  logic [31:0] id_word = EXP_ID;
  logic [31:0] ts_word = EXP_TS;
  int unsigned stall_id = 0, stall_ts = 0;
  int unsigned cnt_id, cnt_ts;
  int unsigned hold_viol;
  logic prev_wait, prev_addr;

  assign bus.m_waitrequest = bus.m_read && (bus.m_address ? (cnt_ts < stall_ts) : (cnt_id < stall_id));
  assign bus.m_readdata    = bus.m_address ? ts_word : id_word;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_id    <= 0;
      cnt_ts    <= 0;
      prev_wait <= 1'b0;
      prev_addr <= 1'b0;
    end else begin
      if (start && !busy) begin
        cnt_id <= 0;
        cnt_ts <= 0;
      end else if (bus.m_read && bus.m_waitrequest) begin
        if (bus.m_address) cnt_ts <= cnt_ts + 1;
        else               cnt_id <= cnt_id + 1;
      end
      if (prev_wait && !(bus.m_read && bus.m_address == prev_addr)) hold_viol <= hold_viol + 1;
      prev_wait <= bus.m_read && bus.m_waitrequest;
      prev_addr <= bus.m_address;
    end
  end
  initial hold_viol = 0;

  // Pulse start (caller sits just after a posedge) and wait for done; cyc is the cycle number
  // where done was seen, counting the cycle after the start edge as 1.
  task automatic run_main(output int cyc, output bit got);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 1;
    got = 1'b0;
    while (cyc < 300) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0;
    #12;
    checks++;
    if ({busy, done, pass, id_err, ts_err, timeout_err, bus.m_read, bus.m_address} !== 8'd0 ||
        id_value !== 32'd0 || ts_value !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b id=%0d ts=%0d, required all 0",
               {busy, done, pass, id_err, ts_err, timeout_err, bus.m_read, bus.m_address},
               id_value, ts_value);
    end
    checks++;
    if (t_busy !== 1'b0 || tbus.m_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_t_idle: busy=%b m_read=%b, required 0 0", t_busy, tbus.m_read);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    n = 0;
    while (!done && n < 30) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL auto_start: done=%b pass=%b tmo=%b, required 1 1 0", done, pass, timeout_err);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_nominal();
    int cyc;
    bit got;
    id_word = EXP_ID; ts_word = EXP_TS; stall_id = 0; stall_ts = 0;
    run_main(cyc, got);
    checks++;
    if (!got || cyc != 4) begin
      errors++;
      $display("FAIL nominal_latency: done cycle %0d (seen=%0d), required 4", cyc, got);
    end
    checks++;
    if ({pass, id_err, ts_err, timeout_err, busy} !== 5'b10000 || id_value !== EXP_ID) begin
      errors++;
      $display("FAIL nominal_flags: p/ie/te/to/busy=%b id=%0d, required 10000 id=28",
               {pass, id_err, ts_err, timeout_err, busy}, id_value);
    end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_single: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_mismatch();
    int cyc;
    bit got;
    id_word = 32'd29; ts_word = EXP_TS; stall_id = 0; stall_ts = 0;
    run_main(cyc, got);
    checks++;
    if (!got || {id_err, ts_err, pass} !== 3'b100 || id_value !== 32'd29) begin
      errors++;
      $display("FAIL mismatch: ie/te/p=%b id=%0d, required 100 id=29", {id_err, ts_err, pass},
               id_value);
    end
    id_word = EXP_ID;
    @(posedge clock); #1;
  endtask

  task automatic test_stall();
    int cyc;
    bit got;
    int unsigned v0;
    v0 = hold_viol;
    stall_id = 0; stall_ts = 10;
    run_main(cyc, got);
    checks++;
    if (!got || cyc != 14) begin
      errors++;
      $display("FAIL stall_latency: done cycle %0d, required 14", cyc);
    end
    checks++;
    if (pass !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL stall_flags: pass=%b tmo=%b, required 1 0", pass, timeout_err);
    end
    checks++;
    if (hold_viol != v0) begin
      errors++;
      $display("FAIL stall_hold: %0d hold violations, required 0", hold_viol - v0);
    end
    stall_ts = 0;
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    int cyc;
    bit got;
    int exp_cyc;
    logic [3:0] exp_flags;
    for (int i = 0; i < 20; i++) begin
      id_word  = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      ts_word  = ($urandom_range(0, 1) == 1) ? EXP_TS : (EXP_TS ^ (32'd1 << $urandom_range(0, 31)));
      stall_id = $urandom_range(0, 12);
      stall_ts = $urandom_range(0, 12);
      exp_cyc  = 4 + int'(stall_id) + int'(stall_ts);
      exp_flags = {(id_word == EXP_ID) && (ts_word == EXP_TS), id_word != EXP_ID,
                   ts_word != EXP_TS, 1'b0};
      run_main(cyc, got);
      checks++;
      if (!got || cyc != exp_cyc || {pass, id_err, ts_err, timeout_err} !== exp_flags ||
          id_value !== id_word || ts_value !== ts_word) begin
        errors++;
        $display("FAIL random_%0d: cyc=%0d flags=%b id=%h ts=%h, required cyc=%0d flags=%b id=%h ts=%h",
                 i, cyc, {pass, id_err, ts_err, timeout_err}, id_value, ts_value,
                 exp_cyc, exp_flags, id_word, ts_word);
      end
      @(posedge clock); #1;
    end
    id_word = EXP_ID; ts_word = EXP_TS; stall_id = 0; stall_ts = 0;
  endtask

  task automatic test_permanent_stall();
    int cyc, highs, zeros, rises, bad_addr;
    bit got, prev;
    highs = 0; zeros = 0; rises = 0; bad_addr = 0; prev = 1'b0; got = 1'b0;
    start_t = 1'b1;
    @(posedge clock); #1;
    start_t = 1'b0;
    cyc = 1;
    while (cyc < 100) begin
      if (t_done) begin
        got = 1'b1;
        break;
      end
      if (tbus.m_read) highs++; else zeros++;
      if (tbus.m_read && !prev) rises++;
      if (tbus.m_address !== 1'b0) bad_addr++;
      prev = tbus.m_read;
      @(posedge clock); #1;
      cyc++;
    end
    checks++;
    if (!got || cyc != 1 + (T_RETRIES + 1) * (T_TIMEOUT + 1)) begin
      errors++;
      $display("FAIL perm_latency: done cycle %0d, required %0d", cyc,
               1 + (T_RETRIES + 1) * (T_TIMEOUT + 1));
    end
    checks++;
    if (rises != T_RETRIES + 1 || highs != (T_RETRIES + 1) * T_TIMEOUT ||
        zeros != T_RETRIES + 1 || bad_addr != 0) begin
      errors++;
      $display("FAIL perm_attempts: rises=%0d highs=%0d gaps=%0d badaddr=%0d, required 2 8 2 0",
               rises, highs, zeros, bad_addr);
    end
    checks++;
    if ({t_timeout_err, t_pass, t_id_err, t_ts_err, t_busy} !== 5'b10000) begin
      errors++;
      $display("FAIL perm_flags: to/p/ie/te/busy=%b, required 10000",
               {t_timeout_err, t_pass, t_id_err, t_ts_err, t_busy});
    end
  endtask

  task automatic test_reset_mid();
    int n;
    stall_ts = 8;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (!(bus.m_read && bus.m_address) && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, pass, id_err, ts_err, timeout_err, bus.m_read} !== 7'd0 ||
        id_value !== 32'd0 || ts_value !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: flags=%b id=%0d ts=%0d, required all 0",
               {busy, done, pass, id_err, ts_err, timeout_err, bus.m_read}, id_value, ts_value);
    end
    stall_ts = 0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    n = 0;
    while (!done && n < 30) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || ts_value !== EXP_TS) begin
      errors++;
      $display("FAIL reset_restart: done=%b pass=%b ts=%0d, required 1 1 %0d", done, pass,
               ts_value, EXP_TS);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_busy_start();
    int cyc, dones, done_cyc;
    bit got;
    id_word = 32'd29; stall_id = 3; stall_ts = 0;
    start = 1'b1;
    @(posedge clock); #1;
    // Cycle 1: RD_ID, stalled; this start must be ignored.
    @(posedge clock); #1;
    start = 1'b0;
    dones = 0; done_cyc = 0;
    for (int c = 2; c < 30; c++) begin
      if (done) begin
        dones++;
        done_cyc = c;
      end
      @(posedge clock); #1;
    end
    checks++;
    if (dones != 1 || done_cyc != 7 || id_err !== 1'b1) begin
      errors++;
      $display("FAIL busy_start: dones=%0d at cycle %0d id_err=%b, required 1 at 7 id_err=1",
               dones, done_cyc, id_err);
    end
    id_word = EXP_ID; stall_id = 0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    checks++;
    if ({id_err, ts_err, timeout_err, pass} !== 4'd0) begin
      errors++;
      $display("FAIL restart_clear: ie/te/to/p=%b, required 0000",
               {id_err, ts_err, timeout_err, pass});
    end
    cyc = 1; got = 1'b0;
    while (cyc < 30) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clock); #1;
      cyc++;
    end
    checks++;
    if (!got || pass !== 1'b1 || id_err !== 1'b0) begin
      errors++;
      $display("FAIL restart_pass: done=%b pass=%b id_err=%b, required 1 1 0", got, pass, id_err);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_mismatch();
    test_stall();
    test_random();
    test_permanent_stall();
    test_busy_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Avalon-MM master that sits directly downstream of the system ID slave and consumes its two read-only words. After reset, or on a `start` pulse, it reads the ID word (address 0) and the timestamp word (address 1), then compares each against build-time expected values. It publishes the result as sticky pass/error flags that firmware or a boot LED can use to reject a mismatched bitstream/software pairing. Stalled reads are bounded by a per-attempt timeout with limited retries.

## Interface
Parameters:
- `EXPECTED_ID`, 28: expected value at sysid address 0.
- `EXPECTED_TS`, 1718188374: expected value at sysid address 1.
- `TIMEOUT`, 255: stalled cycles allowed per read attempt. 0 disables the timeout. Counter width is 16 bits.
- `RETRIES`, 3: extra attempts per read after a timeout. Counter width is 4 bits.
- `AUTO_START`, 1: when 1, one check runs automatically after reset is released.

Ports:
- `clock` in 1: the single clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `start` in 1: single-cycle request to run a check.
- `m_address` out 1: sysid word select.
- `m_read` out 1: read request.
- `m_waitrequest` in 1: fabric stall.
- `m_readdata` in 32: read data, valid in the cycle where `m_read`=1 and `m_waitrequest`=0.
- `busy` out 1: a check is in progress.
- `done` out 1: one-cycle pulse at the end of a check.
- `pass` out 1: sticky; both words matched.
- `id_err`, `ts_err`, `timeout_err` out 1 each: sticky error flags.
- `id_value`, `ts_value` out 32 each: last captured words.

## Operation
- States: IDLE, RD_ID, RD_TS, GAP, CHECK.
- Reset values: state IDLE if AUTO_START=0, or RD_ID if AUTO_START=1. All outputs 0. Retry and timeout counters 0.
- IDLE:
  - `start`=1 goes to RD_ID and clears `pass` and all error flags.
  - `start` in any other state is ignored.
- RD_ID / RD_TS:
  - `m_read`=1 with `m_address`=0 or 1. Both are held stable while `m_waitrequest`=1.
  - On an accepted cycle (`m_waitrequest`=0), capture `m_readdata` into `id_value`/`ts_value`, clear the timeout counter, and advance (RD_ID to RD_TS, RD_TS to CHECK).
- Timeout:
  - Each stalled cycle increments the timeout counter.
  - When it reaches TIMEOUT (TIMEOUT≠0), drop `m_read` and clear the counter.
  - If retries used < RETRIES: increment the retry counter and go to GAP for 1 cycle with `m_read`=0, then re-issue the same address.
  - Otherwise: set `timeout_err`, pulse `done`, go to IDLE. `pass`=0; `id_err`/`ts_err` unchanged (0).
- The retry budget is shared by both reads within one check and is cleared at check start.
- CHECK:
  - `id_err` = (`id_value` ≠ EXPECTED_ID); `ts_err` = (`ts_value` ≠ EXPECTED_TS).
  - `pass` = !id_err & !ts_err.
  - The flags are registered together with the `done` pulse, then the block returns to IDLE.
- `busy` = 1 in every state except IDLE.
- Comparisons are full 32-bit, unsigned equality.
- Reset mid-check aborts immediately: no `done`, flags 0. With AUTO_START=1 a fresh check starts after release.

## Timing
- The `m_*` outputs are registered. `m_read` is never high in IDLE, GAP or CHECK.
- Zero-stall latency: `start` sampled at edge 0. RD_ID is issued in cycle 1 and RD_TS in cycle 2. CHECK occupies cycle 3. `done` and the final flags are visible in cycle 4, the same cycle `busy` falls.
- Each stalled cycle adds exactly 1 cycle. Each timed-out attempt costs TIMEOUT cycles plus 1 GAP cycle.
- `done` is high for exactly one cycle. The flags stay stable until the next check starts.

## Test plan
- **Nominal:** slave returns 28 / 1718188374 with no stalls, pulse `start`. Required: `done` in cycle 4; `pass`=1; all error flags 0; `id_value`=28.
- **Mismatch:** ID word returns 29, TS word correct. Required: `id_err`=1, `ts_err`=0, `pass`=0, `id_value`=29.
- **Stall:** `m_waitrequest`=1 for 10 cycles on RD_TS. Required: address and read held stable throughout; `done` in cycle 14; `pass`=1; no timeout.
- **Permanent stall:** TIMEOUT=4, RETRIES=1. Required: two attempts at address 0 with one `m_read`=0 gap between them; `timeout_err`=1 and `done` in cycle 11; `pass`=0.
- **Reset mid-read:** assert `reset_n`=0 while in RD_TS. Required: outputs 0 immediately. With AUTO_START=1, a new check runs after release and passes.
- **Busy start:** pulse `start` during RD_ID. Required: ignored, with exactly one `done` pulse. A `start` after `done` clears the flags and reruns the check.
